// File: rtl/rgmii_phy_end.sv
// PHY-side RGMII end: GMII rx byte -> RGMII SDR ODDR words, RGMII IDDR words -> GMII tx byte, 10/100/1000.
// Latency: 1 cycle at 1000M; at 10/100M rx ready every 2N cycles, tx byte one cycle after the high-nibble falling edge.
// Backpressure: phy_gmii_rx_ready paces the PHY core; no tx backpressure. `RGMII_PHY_INBAND_STATUS_EN adds in-band status on idle rxd.
module rgmii_phy_end #(
   parameter int CNT_10M  = 50,
   parameter int CNT_100M = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   input  logic [7:0] phy_gmii_rxd,
   input  logic       phy_gmii_rx_dv,
   input  logic       phy_gmii_rx_er,
   output logic       phy_gmii_rx_ready,
   output logic       rgmii_rx_clk_1,
   output logic       rgmii_rx_clk_2,
   output logic [3:0] rgmii_rxd_1,
   output logic [3:0] rgmii_rxd_2,
   output logic       rgmii_rx_ctl_1,
   output logic       rgmii_rx_ctl_2,
   input  logic       rgmii_tx_clk_s,
   input  logic [3:0] rgmii_txd_1,
   input  logic [3:0] rgmii_txd_2,
   input  logic       rgmii_tx_ctl_1,
   input  logic       rgmii_tx_ctl_2,
   output logic [7:0] phy_gmii_txd,
   output logic       phy_gmii_tx_en,
   output logic       phy_gmii_tx_er,
   output logic       phy_gmii_tx_valid,
   output logic       tx_odd_nibble,
   input  logic       link_up,
   input  logic [1:0] link_speed,
   input  logic       full_duplex
);

   localparam int CMAX = (CNT_10M > CNT_100M) ? CNT_10M : CNT_100M;
   localparam int CW   = $clog2(CMAX);
   localparam logic [CW-1:0] LAST_10  = CW'(CNT_10M - 1);
   localparam logic [CW-1:0] LAST_100 = CW'(CNT_100M - 1);
   // odd periods give the extra cycle to the low half of the rx clock
   localparam logic [CW-1:0] HALF_10  = CW'((CNT_10M + 1) / 2);
   localparam logic [CW-1:0] HALF_100 = CW'((CNT_100M + 1) / 2);

   typedef enum logic [1:0] {TX_IDLE, TX_LO, TX_BYTE} tx_state_t;

   logic [1:0]    speed_q;
   logic          gig, spd_chg;
   logic [CW-1:0] cnt, cnt_nxt, last, half;
   logic          wrap, fetch, clk_hi, rx_hi_phase, rx_phase_nxt;
   logic [3:0]    rx_hi_nib, status_nib, lo_nib_nxt, hi_nib_nxt;
   logic          rx_dv_q, rx_er_q, dv_nxt, er_nxt, rx_idle;

`ifdef RGMII_PHY_INBAND_STATUS_EN
   assign status_nib = {full_duplex, link_speed, link_up};
`else
   logic unused_status;
   assign unused_status = ^{full_duplex, link_speed, link_up};
   assign status_nib    = 4'h0;
`endif

   assign gig     = speed[1];
   assign spd_chg = (speed != speed_q);
   assign rx_idle = !phy_gmii_rx_dv && !phy_gmii_rx_er;

   always_comb begin
      last         = speed[0] ? LAST_100 : LAST_10;
      half         = speed[0] ? HALF_100 : HALF_10;
      wrap         = (cnt == last);
      cnt_nxt      = wrap ? '0 : cnt + 1'b1;
      clk_hi       = (cnt_nxt >= half);
      fetch        = wrap && rx_hi_phase;
      rx_phase_nxt = wrap ? !rx_hi_phase : rx_hi_phase;
      dv_nxt       = fetch ? phy_gmii_rx_dv : rx_dv_q;
      er_nxt       = fetch ? phy_gmii_rx_er : rx_er_q;
      lo_nib_nxt   = rx_idle ? status_nib : phy_gmii_rxd[3:0];
      hi_nib_nxt   = rx_idle ? status_nib : phy_gmii_rxd[7:4];
   end

   always_ff @(posedge clk) begin
      if (rst || spd_chg) begin
         speed_q           <= speed;
         cnt               <= '0;
         rx_hi_phase       <= 1'b1;
         rx_hi_nib         <= 4'h0;
         rx_dv_q           <= 1'b0;
         rx_er_q           <= 1'b0;
         phy_gmii_rx_ready <= 1'b0;
         rgmii_rx_clk_1    <= 1'b1;
         rgmii_rx_clk_2    <= 1'b0;
         rgmii_rxd_1       <= 4'h0;
         rgmii_rxd_2       <= 4'h0;
         rgmii_rx_ctl_1    <= 1'b0;
         rgmii_rx_ctl_2    <= 1'b0;
      end else if (gig) begin
         cnt               <= '0;
         rx_hi_phase       <= 1'b1;
         phy_gmii_rx_ready <= 1'b1;
         rgmii_rx_clk_1    <= 1'b1;
         rgmii_rx_clk_2    <= 1'b0;
         rgmii_rxd_1       <= lo_nib_nxt;
         rgmii_rxd_2       <= hi_nib_nxt;
         rgmii_rx_ctl_1    <= phy_gmii_rx_dv;
         rgmii_rx_ctl_2    <= phy_gmii_rx_dv ^ phy_gmii_rx_er;
      end else begin
         cnt               <= cnt_nxt;
         rx_hi_phase       <= rx_phase_nxt;
         phy_gmii_rx_ready <= (cnt_nxt == last) && rx_phase_nxt;
         rgmii_rx_clk_1    <= clk_hi;
         rgmii_rx_clk_2    <= clk_hi;
         rgmii_rx_ctl_1    <= clk_hi ? (dv_nxt ^ er_nxt) : dv_nxt;
         rgmii_rx_ctl_2    <= clk_hi ? (dv_nxt ^ er_nxt) : dv_nxt;
         if (fetch) begin
            rx_hi_nib   <= hi_nib_nxt;
            rx_dv_q     <= phy_gmii_rx_dv;
            rx_er_q     <= phy_gmii_rx_er;
            rgmii_rxd_1 <= lo_nib_nxt;
            rgmii_rxd_2 <= lo_nib_nxt;
         end else if (wrap) begin
            rgmii_rxd_1 <= rx_hi_nib;
            rgmii_rxd_2 <= rx_hi_nib;
         end
      end
   end

   // TX: TX_LO holds a low nibble awaiting its high half, TX_BYTE a full byte awaiting the falling edge
   tx_state_t  tx_state, tx_state_nxt;
   logic       tx_clk_q, rise, fall, tx_en_q, emit, odd;
   logic [3:0] tx_lo, tx_hi;

   assign rise = rgmii_tx_clk_s && !tx_clk_q;
   assign fall = !rgmii_tx_clk_s && tx_clk_q;

   always_ff @(posedge clk) begin
      if (rst || spd_chg || gig) tx_state <= TX_IDLE;
      else                       tx_state <= tx_state_nxt;
   end

   always_comb begin
      tx_state_nxt = tx_state;
      case (tx_state)
         TX_IDLE: if (rise && rgmii_tx_ctl_1) tx_state_nxt = TX_LO;
         TX_LO:   if (rise) tx_state_nxt = rgmii_tx_ctl_1 ? TX_BYTE : TX_IDLE;
         TX_BYTE: if (fall) tx_state_nxt = TX_IDLE;
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      emit = (tx_state == TX_BYTE) && fall;
      odd  = (tx_state == TX_LO) && rise && !rgmii_tx_ctl_1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_clk_q          <= 1'b0;
         tx_en_q           <= 1'b0;
         tx_lo             <= 4'h0;
         tx_hi             <= 4'h0;
         phy_gmii_txd      <= 8'h00;
         phy_gmii_tx_en    <= 1'b0;
         phy_gmii_tx_er    <= 1'b0;
         phy_gmii_tx_valid <= 1'b0;
         tx_odd_nibble     <= 1'b0;
      end else begin
         tx_clk_q <= rgmii_tx_clk_s;
         if (spd_chg) begin
            tx_en_q           <= 1'b0;
            phy_gmii_tx_en    <= 1'b0;
            phy_gmii_tx_er    <= 1'b0;
            phy_gmii_tx_valid <= 1'b0;
            tx_odd_nibble     <= 1'b0;
         end else if (gig) begin
            phy_gmii_txd      <= {rgmii_txd_2, rgmii_txd_1};
            phy_gmii_tx_en    <= rgmii_tx_ctl_1;
            phy_gmii_tx_er    <= rgmii_tx_ctl_1 ^ rgmii_tx_ctl_2;
            phy_gmii_tx_valid <= 1'b1;
            tx_odd_nibble     <= 1'b0;
         end else begin
            phy_gmii_tx_valid <= emit;
            tx_odd_nibble     <= odd;
            if (rise) begin
               tx_en_q <= rgmii_tx_ctl_1;
               if (tx_state == TX_IDLE) tx_lo <= rgmii_txd_1;
               if (tx_state == TX_LO)   tx_hi <= rgmii_txd_1;
               if (!rgmii_tx_ctl_1) begin
                  phy_gmii_tx_en <= 1'b0;
                  phy_gmii_tx_er <= 1'b0;
               end
            end
            if (emit) begin
               phy_gmii_txd   <= {tx_hi, tx_lo};
               phy_gmii_tx_en <= 1'b1;
               phy_gmii_tx_er <= tx_en_q ^ rgmii_tx_ctl_1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rgmii_phy_end.sv
// Directed bench for rgmii_phy_end: 1000M vector table plus 100M rx, 10M/100M tx, speed change and reset sequences.
module tb_rgmii_phy_end;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] speed;
   logic [7:0] phy_gmii_rxd;
   logic       phy_gmii_rx_dv, phy_gmii_rx_er, phy_gmii_rx_ready;
   logic       rgmii_rx_clk_1, rgmii_rx_clk_2, rgmii_rx_ctl_1, rgmii_rx_ctl_2;
   logic [3:0] rgmii_rxd_1, rgmii_rxd_2;
   logic       rgmii_tx_clk_s;
   logic [3:0] rgmii_txd_1, rgmii_txd_2;
   logic       rgmii_tx_ctl_1, rgmii_tx_ctl_2;
   logic [7:0] phy_gmii_txd;
   logic       phy_gmii_tx_en, phy_gmii_tx_er, phy_gmii_tx_valid, tx_odd_nibble;
   logic       link_up, full_duplex;
   logic [1:0] link_speed;

   rgmii_phy_end dut (
      .clk(clk), .rst(rst), .speed(speed),
      .phy_gmii_rxd(phy_gmii_rxd), .phy_gmii_rx_dv(phy_gmii_rx_dv), .phy_gmii_rx_er(phy_gmii_rx_er),
      .phy_gmii_rx_ready(phy_gmii_rx_ready),
      .rgmii_rx_clk_1(rgmii_rx_clk_1), .rgmii_rx_clk_2(rgmii_rx_clk_2),
      .rgmii_rxd_1(rgmii_rxd_1), .rgmii_rxd_2(rgmii_rxd_2),
      .rgmii_rx_ctl_1(rgmii_rx_ctl_1), .rgmii_rx_ctl_2(rgmii_rx_ctl_2),
      .rgmii_tx_clk_s(rgmii_tx_clk_s), .rgmii_txd_1(rgmii_txd_1), .rgmii_txd_2(rgmii_txd_2),
      .rgmii_tx_ctl_1(rgmii_tx_ctl_1), .rgmii_tx_ctl_2(rgmii_tx_ctl_2),
      .phy_gmii_txd(phy_gmii_txd), .phy_gmii_tx_en(phy_gmii_tx_en), .phy_gmii_tx_er(phy_gmii_tx_er),
      .phy_gmii_tx_valid(phy_gmii_tx_valid), .tx_odd_nibble(tx_odd_nibble),
      .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex)
   );

   always #4 clk = ~clk;

`ifdef RGMII_PHY_INBAND_STATUS_EN
   localparam logic [3:0] IDLE_NIB = 4'hD;
`else
   localparam logic [3:0] IDLE_NIB = 4'h0;
`endif

   // {ready, clk_1, clk_2, rxd_1, rxd_2, ctl_1, ctl_2} and {txd, en, er, valid, odd}
   logic [12:0] rx_obs;
   logic [11:0] tx_obs;
   assign rx_obs = {phy_gmii_rx_ready, rgmii_rx_clk_1, rgmii_rx_clk_2, rgmii_rxd_1, rgmii_rxd_2,
                    rgmii_rx_ctl_1, rgmii_rx_ctl_2};
   assign tx_obs = {phy_gmii_txd, phy_gmii_tx_en, phy_gmii_tx_er, phy_gmii_tx_valid, tx_odd_nibble};

   localparam logic [12:0] RX_RST = {1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // tx observation record
   int pnum, vcnt, ocnt, vwhen, owhen;
   logic [7:0] vbyte;
   logic       ven, ver;

   task automatic tx_phase(input logic lev, input logic [3:0] nib, input logic ctl, input int ncyc);
      pnum++;
      rgmii_tx_clk_s = lev;
      rgmii_txd_1    = nib;
      rgmii_tx_ctl_1 = ctl;
      for (int i = 0; i < ncyc; i++) begin
         step();
         if (phy_gmii_tx_valid) begin
            vcnt++;
            vbyte = phy_gmii_txd;
            ven   = phy_gmii_tx_en;
            ver   = phy_gmii_tx_er;
            vwhen = pnum * 100 + i;
         end
         if (tx_odd_nibble) begin
            ocnt++;
            owhen = pnum * 100 + i;
         end
      end
   endtask

   task automatic tx_clear();
      pnum = 0; vcnt = 0; ocnt = 0; vwhen = 0; owhen = 0;
      vbyte = 8'h00; ven = 1'b0; ver = 1'b0;
   endtask

   typedef struct {
      logic [7:0] rxd; logic dv; logic er;
      logic [3:0] t1; logic [3:0] t2; logic c1; logic c2;
      logic [3:0] r1; logic [3:0] r2; logic k1; logic k2;
      logic [7:0] txd; logic en; logic er_o;
   } vec_t;

   vec_t vt[6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'h55, 1'b1, 1'b0, 4'h5, 4'h5, 1'b1, 1'b1, 4'h5, 4'h5, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
      vt[1] = '{8'hD5, 1'b1, 1'b0, 4'hD, 4'h5, 1'b1, 1'b1, 4'h5, 4'hD, 1'b1, 1'b1, 8'h5D, 1'b1, 1'b0};
      vt[2] = '{8'hA7, 1'b1, 1'b0, 4'h7, 4'hA, 1'b1, 1'b0, 4'h7, 4'hA, 1'b1, 1'b1, 8'hA7, 1'b1, 1'b1};
      vt[3] = '{8'h3C, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'hC, 4'h3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[4] = '{8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, IDLE_NIB, IDLE_NIB, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[5] = '{8'hFF, 1'b0, 1'b1, 4'h3, 4'hC, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

      rst = 1'b1; speed = 2'b10;
      phy_gmii_rxd = 8'h00; phy_gmii_rx_dv = 1'b0; phy_gmii_rx_er = 1'b0;
      rgmii_tx_clk_s = 1'b0; rgmii_txd_1 = 4'h0; rgmii_txd_2 = 4'h0;
      rgmii_tx_ctl_1 = 1'b0; rgmii_tx_ctl_2 = 1'b0;
      link_up = 1'b1; link_speed = 2'b10; full_duplex = 1'b1;
      step(); step(); step();
      chk("reset_rx", rx_obs, RX_RST);
      chk("reset_tx", tx_obs, 12'h000);
      rst = 1'b0;

      // 1000M table
      for (int i = 0; i < 6; i++) begin
         phy_gmii_rxd = vt[i].rxd; phy_gmii_rx_dv = vt[i].dv; phy_gmii_rx_er = vt[i].er;
         rgmii_txd_1 = vt[i].t1; rgmii_txd_2 = vt[i].t2;
         rgmii_tx_ctl_1 = vt[i].c1; rgmii_tx_ctl_2 = vt[i].c2;
         step();
         chk($sformatf("g_rx[%0d]", i), rx_obs,
             {1'b1, 1'b1, 1'b0, vt[i].r1, vt[i].r2, vt[i].k1, vt[i].k2});
         chk($sformatf("g_tx[%0d]", i), tx_obs, {vt[i].txd, vt[i].en, vt[i].er_o, 1'b1, 1'b0});
      end

      // 100M rx: byte 0x3C, dv=1, er=1
      rgmii_txd_1 = 4'h0; rgmii_txd_2 = 4'h0; rgmii_tx_ctl_1 = 1'b0; rgmii_tx_ctl_2 = 1'b0;
      rst = 1'b1; speed = 2'b01;
      step(); step();
      rst = 1'b0;
      phy_gmii_rxd = 8'h3C; phy_gmii_rx_dv = 1'b1; phy_gmii_rx_er = 1'b1;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = phy_gmii_rx_ready;
         end
         chk("rx100_ready_seen", {31'd0, seen}, 32'd1);
      end
      for (int k = 1; k <= 10; k++) begin
         logic       hi;
         logic [3:0] nib;
         step();
         hi  = ((k - 1) % 5) >= 3;
         nib = (k <= 5) ? 4'hC : 4'h3;
         chk($sformatf("rx100[%0d]", k), rx_obs, {(k == 10), hi, hi, nib, nib, !hi, !hi});
      end

      // speed change 100M -> 1000M mid-byte
      step();
      speed = 2'b10; phy_gmii_rxd = 8'hA7; phy_gmii_rx_dv = 1'b1; phy_gmii_rx_er = 1'b0;
      step();
      chk("chg_rx", rx_obs, RX_RST);
      chk("chg_valid", {31'd0, phy_gmii_tx_valid}, 32'd0);
      step();
      chk("chg_rx_next", rx_obs, {1'b1, 1'b1, 1'b0, 4'h7, 4'hA, 1'b1, 1'b1});
      chk("chg_valid_next", {31'd0, phy_gmii_tx_valid}, 32'd1);

      // reset mid-frame at 1000M
      rgmii_txd_1 = 4'h9; rgmii_txd_2 = 4'h6; rgmii_tx_ctl_1 = 1'b1;
      step();
      rst = 1'b1;
      step();
      chk("midrst_rx", rx_obs, RX_RST);
      chk("midrst_tx", tx_obs, 12'h000);

      // 10M tx: nibbles A then 5, 25 low / 25 high
      speed = 2'b00; phy_gmii_rx_dv = 1'b0; rgmii_tx_ctl_1 = 1'b0; rgmii_tx_clk_s = 1'b0;
      step();
      rst = 1'b0;
      tx_clear();
      tx_phase(1'b0, 4'h0, 1'b0, 25);
      tx_phase(1'b1, 4'hA, 1'b1, 25);
      tx_phase(1'b0, 4'hA, 1'b1, 25);
      tx_phase(1'b1, 4'h5, 1'b1, 25);
      tx_phase(1'b0, 4'h5, 1'b1, 25);
      tx_phase(1'b1, 4'h0, 1'b0, 25);
      tx_phase(1'b0, 4'h0, 1'b0, 25);
      chk("tx10_count", vcnt, 1);
      chk("tx10_byte", {vbyte, ven, ver}, {8'h5A, 1'b1, 1'b0});
      chk("tx10_when", vwhen, 500);
      chk("tx10_odd", ocnt, 0);

      // 100M tx odd frame: nibbles 1,2 (er at fall), 3, then en drops
      rst = 1'b1; speed = 2'b01; rgmii_tx_clk_s = 1'b0; rgmii_tx_ctl_1 = 1'b0;
      step(); step();
      rst = 1'b0;
      tx_clear();
      tx_phase(1'b0, 4'h0, 1'b0, 3);
      tx_phase(1'b1, 4'h1, 1'b1, 2);
      tx_phase(1'b0, 4'h1, 1'b1, 3);
      tx_phase(1'b1, 4'h2, 1'b1, 2);
      tx_phase(1'b0, 4'h2, 1'b0, 3);
      tx_phase(1'b1, 4'h3, 1'b1, 2);
      tx_phase(1'b0, 4'h3, 1'b1, 3);
      tx_phase(1'b1, 4'h0, 1'b0, 2);
      tx_phase(1'b0, 4'h0, 1'b0, 3);
      tx_phase(1'b1, 4'h0, 1'b0, 2);
      tx_phase(1'b0, 4'h0, 1'b0, 3);
      chk("odd_count", vcnt, 1);
      chk("odd_byte", {vbyte, ven, ver}, {8'h21, 1'b1, 1'b1});
      chk("odd_byte_when", vwhen, 500);
      chk("odd_pulses", ocnt, 1);
      chk("odd_pulse_when", owhen, 800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
